// File: rtl/router_pkg.sv
// Shared definitions for the instruction router: route encodings, FSM states
// and the destination-field position helper.
package router_pkg;

  localparam logic [1:0] EN_SELF  = 2'b01;
  localparam logic [1:0] EN_LEFT  = 2'b00;
  localparam logic [1:0] EN_RIGHT = 2'b10;
  localparam logic [1:0] EN_IDLE  = 2'b11;

  typedef enum logic {
    IDLE  = 1'b0,
    DRIVE = 1'b1
  } state_t;

  // LSB index of the destination field, which occupies the top addr_width bits.
  function automatic int dest_lsb(input int instr_w, input int dest_w);
    return instr_w - dest_w;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Synchronous power-of-two FIFO with async reset; the head entry is read
// straight out of the storage flops so it is visible the cycle after a push.
module instr_fifo #(
  parameter int width = 32,
  parameter int depth = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [width-1:0]         wr_data,
  input  logic                     pop,
  output logic [width-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(depth):0]   level
);

  localparam int AW = $clog2(depth);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(depth);

  logic [width-1:0] mem_q [depth];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             do_push, do_pop;

  assign full    = (level_q == DEPTH_L);
  assign empty   = (level_q == '0);
  // A full FIFO refuses a push even when a pop frees a slot on the same edge.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem_q[rd_ptr_q];
  assign level   = level_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/instr_router.sv
// Ring dispatch stage: buffers instructions, decodes the destination node into
// a self/left/right route and holds each dispatch for hold_cycles cycles.
module instr_router
  import router_pkg::*;
#(
  parameter int                    width       = 32,
  parameter int                    addr_width  = 8,
  parameter logic [addr_width-1:0] node_addr   = 8'd0,
  parameter int                    num_nodes   = 8,
  parameter int                    depth       = 4,
  parameter int                    hold_cycles = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [width-1:0]       in_instr,
  output logic                   in_ready,
  input  logic                   out_stall,
  output logic [1:0]             enable,
  output logic [width-1:0]       out_instr,
  output logic                   busy,
  output logic [$clog2(depth):0] fifo_level,
  output logic [7:0]             drop_count
);

  localparam int DLSB = dest_lsb(width, addr_width);
  localparam int HW   = (hold_cycles > 1) ? $clog2(hold_cycles) : 1;
  localparam logic [HW-1:0]       HOLD_INIT = HW'(hold_cycles - 1);
  localparam logic [addr_width:0] NUM_L     = (addr_width+1)'(num_nodes);
  localparam logic [addr_width:0] HALF_L    = (addr_width+1)'(num_nodes / 2);

  state_t           state_q, state_d;
  logic [1:0]       enable_q, enable_d;
  logic [width-1:0] out_instr_q, out_instr_d;
  logic [HW-1:0]    hold_cnt_q, hold_cnt_d;
  logic [7:0]       drop_q, drop_d;

  logic [width-1:0]      head;
  logic                  full, empty, pop, load, drop;
  logic [addr_width-1:0] dest;
  logic [addr_width:0]   sum, diff;
  logic                  dest_ok;
  logic [1:0]            route;

  instr_fifo #(
    .width (width),
    .depth (depth)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (in_valid),
    .wr_data (in_instr),
    .pop     (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .level   (fifo_level)
  );

  // Ring distance measured rightwards; a half-ring tie resolves to the right.
  assign dest    = head[DLSB +: addr_width];
  assign dest_ok = ({1'b0, dest} < NUM_L);
  assign sum     = {1'b0, dest} + NUM_L - {1'b0, node_addr};
  assign diff    = (sum >= NUM_L) ? (sum - NUM_L) : sum;
  assign route   = (dest == node_addr) ? EN_SELF :
                   (diff <= HALF_L)    ? EN_RIGHT : EN_LEFT;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      enable_q    <= EN_IDLE;
      out_instr_q <= '0;
      hold_cnt_q  <= '0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      enable_q    <= enable_d;
      out_instr_q <= out_instr_d;
      hold_cnt_q  <= hold_cnt_d;
      drop_q      <= drop_d;
    end
  end

  // The exit cycle of a dispatch pops and decodes the next head directly.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    load    = 1'b0;
    drop    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          if (dest_ok) begin
            load    = 1'b1;
            state_d = DRIVE;
          end else begin
            drop = 1'b1;
          end
        end
      end
      DRIVE: begin
        if (!out_stall && hold_cnt_q == '0) begin
          state_d = IDLE;
          if (!empty) begin
            pop = 1'b1;
            if (dest_ok) begin
              load    = 1'b1;
              state_d = DRIVE;
            end else begin
              drop = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    enable_d    = enable_q;
    out_instr_d = out_instr_q;
    hold_cnt_d  = hold_cnt_q;
    drop_d      = drop_q;
    if (load) begin
      enable_d    = route;
      out_instr_d = head;
      hold_cnt_d  = HOLD_INIT;
    end else if (state_d == IDLE) begin
      enable_d = EN_IDLE;
    end else if (state_q == DRIVE && !out_stall) begin
      hold_cnt_d = hold_cnt_q - HW'(1);
    end
    if (drop && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
  end

  assign in_ready   = !full;
  assign enable     = enable_q;
  assign out_instr  = out_instr_q;
  assign busy       = (state_q == DRIVE);
  assign drop_count = drop_q;

endmodule

// File: tb/tb_instr_router.sv
// Self-checking bench for instr_router on node 2 of an 8-node ring.
module tb_instr_router;
  import router_pkg::*;

  localparam int HOLD = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = '0;
  logic        out_stall = 1'b0;
  logic        in_ready;
  logic [1:0]  enable;
  logic [31:0] out_instr;
  logic        busy;
  logic [2:0]  fifo_level;
  logic [7:0]  drop_count;

  instr_router #(
    .width       (32),
    .addr_width  (8),
    .node_addr   (8'd2),
    .num_nodes   (8),
    .depth       (4),
    .hold_cycles (HOLD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_instr   (in_instr),
    .in_ready   (in_ready),
    .out_stall  (out_stall),
    .enable     (enable),
    .out_instr  (out_instr),
    .busy       (busy),
    .fifo_level (fifo_level),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  en;
    logic [31:0] instr;
  } exp_t;

  typedef struct {
    logic [7:0] dest;
    bit         ok;
    logic [1:0] en;
  } vec_t;

  exp_t        q[$];
  exp_t        cur;
  vec_t        tbl[12];
  int          total = 0;
  int          bad = 0;
  int          rem = 0;
  int          exp_drops = 0;
  logic [23:0] tag = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: bound expired", name);
  endtask

  task automatic push(input logic [7:0] dest, input bit ok, input logic [1:0] en);
    int t = 0;
    tag = tag + 24'd1;
    in_instr = {dest, tag};
    in_valid = 1'b1;
    while (!in_ready && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) begin
      fail_now("push_wait");
      in_valid = 1'b0;
      return;
    end
    if (ok) q.push_back('{en, {dest, tag}});
    else if (exp_drops < 255) exp_drops++;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while ((busy || fifo_level != 3'd0) && t < 3000) begin
      @(posedge clk); #1;
      t++;
    end
    @(posedge clk); #1;
    chk({name, "_idle"}, {62'd0, busy, (fifo_level != 3'd0)}, 64'd0);
    chk({name, "_sb_empty"}, q.size(), 0);
  endtask

  // Scoreboard monitor: each dispatch must match the queue head and last HOLD
  // unstalled cycles; enable must read idle whenever the FSM is not driving.
  always @(negedge clk) begin
    if (reset) begin
      rem = 0;
    end else if (busy) begin
      if (rem == 0) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_dispatch: got en=%0h instr=%0h", enable, out_instr);
        end else begin
          cur = q.pop_front();
          chk("disp_en", enable, cur.en);
          chk("disp_instr", out_instr, cur.instr);
        end
        rem = HOLD;
      end else begin
        chk("hold_en", enable, cur.en);
        chk("hold_instr", out_instr, cur.instr);
      end
      if (!out_stall) rem--;
    end else begin
      if (rem != 0) chk("hold_short", rem, 0);
      rem = 0;
      chk("idle_en", enable, EN_IDLE);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] lat_instr;

    tbl[0]  = '{8'd2,   1'b1, EN_SELF};
    tbl[1]  = '{8'd5,   1'b1, EN_RIGHT};
    tbl[2]  = '{8'd6,   1'b1, EN_RIGHT};
    tbl[3]  = '{8'd7,   1'b1, EN_LEFT};
    tbl[4]  = '{8'd9,   1'b0, EN_IDLE};
    tbl[5]  = '{8'd200, 1'b0, EN_IDLE};
    tbl[6]  = '{8'd3,   1'b1, EN_RIGHT};
    tbl[7]  = '{8'd0,   1'b1, EN_LEFT};
    tbl[8]  = '{8'd1,   1'b1, EN_LEFT};
    tbl[9]  = '{8'd4,   1'b1, EN_RIGHT};
    tbl[10] = '{8'd8,   1'b0, EN_IDLE};
    tbl[11] = '{8'd255, 1'b0, EN_IDLE};

    #12;
    chk("rst_enable", enable, EN_IDLE);
    chk("rst_out_instr", out_instr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_level", fifo_level, 0);
    chk("rst_drops", drop_count, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // back-to-back dispatch of the first four table entries
    fork
      begin
        for (int i = 0; i < 4; i++) push(tbl[i].dest, tbl[i].ok, tbl[i].en);
      end
      begin
        int c = 0;
        int t = 0;
        while (!busy && t < 50) begin
          @(negedge clk);
          t++;
        end
        while (busy && c < 50) begin
          c++;
          @(negedge clk);
        end
        chk("b2b_run_len", c, 4 * HOLD);
      end
    join
    wait_idle("grp1");
    chk("grp1_drops", drop_count, exp_drops);

    for (int i = 4; i < 12; i++) push(tbl[i].dest, tbl[i].ok, tbl[i].en);
    wait_idle("grp2");
    chk("grp2_drops", drop_count, exp_drops);

    // backpressure: one stalled dispatch plus four queued fills the FIFO
    out_stall = 1'b1;
    for (int i = 0; i < 5; i++) push(8'(i + 3), 1'b1, (i + 3 == 7) ? EN_LEFT : EN_RIGHT);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_level", fifo_level, 4);
    fork
      push(8'd2, 1'b1, EN_SELF);
      begin
        repeat (3) @(posedge clk);
        #1;
        chk("bp_hold_level", fifo_level, 4);
        chk("bp_hold_ready", in_ready, 0);
        out_stall = 1'b0;
      end
    join
    wait_idle("bp");

    // simultaneous push and pop at level 2
    out_stall = 1'b1;
    push(8'd5, 1'b1, EN_RIGHT);
    push(8'd6, 1'b1, EN_RIGHT);
    push(8'd7, 1'b1, EN_LEFT);
    chk("pp_level_pre", fifo_level, 2);
    out_stall = 1'b0;
    @(posedge clk); #1;
    push(8'd1, 1'b1, EN_LEFT);
    chk("pp_level_same", fifo_level, 2);
    wait_idle("pp");

    // drop counter saturation
    for (int i = 0; i < 260; i++) push(8'd9, 1'b0, EN_IDLE);
    wait_idle("sat");
    chk("sat_drops", drop_count, exp_drops);
    chk("sat_drops_255", drop_count, 255);

    // asynchronous reset in the middle of a stalled dispatch
    out_stall = 1'b1;
    for (int i = 0; i < 4; i++) push(8'd5, 1'b1, EN_RIGHT);
    chk("mid_busy", busy, 1);
    chk("mid_level", fifo_level, 3);
    reset = 1'b1;
    q.delete();
    exp_drops = 0;
    #1;
    chk("arst_enable", enable, EN_IDLE);
    chk("arst_level", fifo_level, 0);
    chk("arst_busy", busy, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_drops", drop_count, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    out_stall = 1'b0;
    @(posedge clk); #1;

    // first-dispatch latency after reset
    push(8'd3, 1'b1, EN_RIGHT);
    lat_instr = {8'd3, tag};
    chk("lat_pre_enable", enable, EN_IDLE);
    @(posedge clk); #1;
    chk("lat_enable", enable, EN_RIGHT);
    chk("lat_instr", out_instr, lat_instr);
    wait_idle("lat");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
